aes_job_sequencer: RTL and testbench
====================================

# aes_job_sequencer

Bus-master controller that runs complete AES-128 encryption jobs on the picoaes memory-mapped peripheral, so software or a DMA engine does not have to issue the register sequence itself. It accepts one {key, plaintext} job on a valid/ready port. It then drives the peripheral's valid/wen/addr/wdata/rdata/ready slave port through key load, plaintext load, start, status polling and ciphertext readout. It returns the 128-bit ciphertext on a valid/ready result port. It sits between the job source and picoaes, and is the only master on that slave port.

## Interface
- POLL_LIMIT, 1024: maximum STATUS reads per job before the job is aborted with an error.
- KEY_CACHE, 1: 1 means key writes are skipped when the job key equals the last successfully loaded key.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- job_valid  in  1  a job is offered.
- job_ready  out  1  the sequencer accepts a job; high only in IDLE.
- job_key  in  128  AES key.
- job_pt  in  128  plaintext.
- res_valid  out  1  result is available.
- res_ready  in  1  the consumer takes the result.
- res_ct  out  128  ciphertext.
- res_err  out  1  set when the job hit the poll timeout; res_ct is then 0.
- m_valid  out  1  bus request to picoaes.
- m_wen  out  1  1 = write, 0 = read.
- m_addr  out  24  byte address.
- m_wdata  out  32  write data.
- m_rdata  in  32  read data.
- m_ready  in  1  the access completes in the cycle where m_valid and m_ready are both high.

## Operation
- Register map (byte addresses):
  - CTRL 0x00
  - KEYW0..3 0x04..0x10
  - PTW0..3 0x14..0x20
  - CTW0..3 0x34..0x40
  - STATUS 0x44; bit0 = done.
- Word order:
  - KEYW3 ← key[31:0] … KEYW0 ← key[127:96]. Writes are issued in the order W3, W2, W1, W0.
  - PTW registers follow the same mapping and order.
  - Reads go CTW3 → ct[31:0] … CTW0 → ct[127:96].
- States and sequence:
  - IDLE: on job_valid && job_ready, latch key and pt.
    - If KEY_CACHE, cache_valid, and the key equals the cached key, go to WPT.
    - Otherwise go to WKEY.
  - WKEY: 4 writes. Invalidate cache_valid on entry.
  - WPT: 4 writes.
  - WCTRL: 4 writes to CTRL with data 0x6, 0x6, 0x4, 0x4. This is the mandatory start sequence.
  - POLL: read STATUS repeatedly.
    - bit0 = 1 → RDCT.
    - After POLL_LIMIT reads with bit0 = 0 → RESP with err = 1, and cache_valid = 0.
  - RDCT: 4 reads.
  - RESP: hold res_valid until res_ready, then return to IDLE.
- Cache update: on a successful RDCT completion, store the key in the cache and set cache_valid = 1.
- A 2-bit word index steps each time an access completes and wraps to 0 on a state change. A 16-bit poll counter resets on entry to POLL.
- Bus outputs:
  - m_valid is high in every non-IDLE, non-RESP state.
  - m_addr, m_wdata and m_wen are stable while m_valid is high and m_ready is low.
  - m_wdata = 0 during reads.

## Timing
- Reset values:
  - job_ready = 0 during reset, 1 in the first cycle after reset.
  - res_valid, res_err, m_valid and m_wen = 0.
  - m_addr, m_wdata and res_ct = 0.
  - cache_valid = 0.
- m_valid rises in the cycle after the accept edge.
- With m_ready tied high each access takes 1 cycle, and res_valid rises N cycles after the accept edge:
  - uncached job: N = 4+4+4+P+4+1;
  - cached job: N = 4+4+P+4+1;
  - P = number of STATUS reads, ≥1.
- m_rdata is sampled on the edge where m_ready is high.
- Back-to-back jobs: job_ready rises in the cycle after the res_valid && res_ready edge. A job and a result cannot be taken in the same cycle.
- Reset mid-job, in any state:
  - next state is IDLE;
  - m_valid drops;
  - the in-flight access is abandoned;
  - cache_valid = 0, because the peripheral's key state is unknown.
- Changes to job_key or job_pt after acceptance have no effect on the running job.

## Structure
- Package aes_seq_pkg holds:
  - the address constants above;
  - the CTRL start sequence values and the STATUS done bit;
  - the state enum (IDLE, WKEY, WPT, WCTRL, POLL, RDCT, RESP).
- No sub-module: a single FSM plus datapath (index, poll counter, key cache, ct shift register) is natural.

## Test plan
- Known-answer job with key fb0b38bcad60b76c73377dfd9ce5692f and pt fb8587bdac1c369369173bceb2ed4785, against the real picoaes → res_ct = 2287d7fc410a4e2059c15b4a2a2b3375, res_err = 0. The bus trace shows address order 0x10,0x0C,0x08,0x04, 0x20…0x14, 0x00×4, 0x44…, 0x40…0x34.
- Second job with the same key and a new pt → no accesses to 0x04–0x10; the ciphertext matches the reference model.
- Slave model with random m_ready stalls (0–3 cycles) → address, data and wen are held stable while stalled; correct result.
- Slave model whose STATUS never sets done, with POLL_LIMIT = 8 → exactly 8 STATUS reads, then res_valid with res_err = 1 and res_ct = 0. The next same-key job reloads the key.
- Reset asserted during WPT → m_valid = 0 on the next cycle and job_ready = 1 after reset is released. The following job rewrites the key.
- res_ready held low for 5 cycles → res_valid and res_ct stay stable and job_ready stays 0 until the handshake completes.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared definitions for the picoaes job sequencer: register map, start
// sequence, FSM state encoding and the bus request encoder.
package aes_seq_pkg;

    localparam logic [23:0] ADDR_CTRL   = 24'h00_0000;
    localparam logic [23:0] ADDR_KEYW0  = 24'h00_0004;
    localparam logic [23:0] ADDR_PTW0   = 24'h00_0014;
    localparam logic [23:0] ADDR_CTW0   = 24'h00_0034;
    localparam logic [23:0] ADDR_STATUS = 24'h00_0044;

    // CTRL start sequence is HI, HI, LO, LO
    localparam logic [31:0] CTRL_START_HI   = 32'h0000_0006;
    localparam logic [31:0] CTRL_START_LO   = 32'h0000_0004;
    localparam int          STATUS_DONE_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        WKEY,
        WPT,
        WCTRL,
        POLL,
        RDCT,
        RESP
    } seq_state_e;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [23:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // Word idx 0 is the least significant 32 bits of the 128-bit value.
    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
        logic [31:0] w;
        w = v[31:0];
        case (idx)
            2'd0: w = v[31:0];
            2'd1: w = v[63:32];
            2'd2: w = v[95:64];
            2'd3: w = v[127:96];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

    // Word idx 0 maps to register W3 (highest address), idx 3 to W0.
    function automatic logic [23:0] word_addr(input logic [23:0] base, input logic [1:0] idx);
        return base + {20'd0, ~idx, 2'b00};
    endfunction

    // Bus request for a given state and word index; all zero when idle.
    function automatic bus_req_t bus_req(input seq_state_e st, input logic [1:0] idx,
                                         input logic [127:0] key, input logic [127:0] pt);
        bus_req_t r;
        r = '0;
        case (st)
            WKEY: begin
                r.valid = 1'b1;
                r.wen   = 1'b1;
                r.addr  = word_addr(ADDR_KEYW0, idx);
                r.wdata = word_sel(key, idx);
            end
            WPT: begin
                r.valid = 1'b1;
                r.wen   = 1'b1;
                r.addr  = word_addr(ADDR_PTW0, idx);
                r.wdata = word_sel(pt, idx);
            end
            WCTRL: begin
                r.valid = 1'b1;
                r.wen   = 1'b1;
                r.addr  = ADDR_CTRL;
                r.wdata = idx[1] ? CTRL_START_LO : CTRL_START_HI;
            end
            POLL: begin
                r.valid = 1'b1;
                r.addr  = ADDR_STATUS;
            end
            RDCT: begin
                r.valid = 1'b1;
                r.addr  = word_addr(ADDR_CTW0, idx);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_job_sequencer.sv
// Runs one complete AES-128 job on the picoaes slave port: optional key load,
// plaintext load, start sequence, STATUS polling and ciphertext readout.
// Bus outputs are registered from the next-state view so they hold steady
// while the slave stalls.
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 1024,
    parameter bit          KEY_CACHE  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [127:0] job_key,
    input  logic [127:0] job_pt,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_ct,
    output logic         res_err,
    output logic         m_valid,
    output logic         m_wen,
    output logic [23:0]  m_addr,
    output logic [31:0]  m_wdata,
    input  logic [31:0]  m_rdata,
    input  logic         m_ready
);

    seq_state_e   state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [15:0]  poll_cnt_q, poll_cnt_d;
    logic         cache_valid_q, cache_valid_d;
    logic         job_ready_q, job_ready_d;
    logic         res_valid_q, res_valid_d;
    logic         res_err_q, res_err_d;
    logic [127:0] res_ct_q, res_ct_d;
    bus_req_t     bus_q, bus_d;
    logic [127:0] key_q, key_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_sh_q, ct_sh_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic         acc_done;
    logic [127:0] ct_next;

    assign acc_done = bus_q.valid && m_ready;
    assign ct_next  = {m_rdata, ct_sh_q[127:32]};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        poll_cnt_d    = poll_cnt_q;
        cache_valid_d = cache_valid_q;
        res_valid_d   = res_valid_q;
        res_err_d     = res_err_q;
        res_ct_d      = res_ct_q;
        key_d         = key_q;
        pt_d          = pt_q;
        ct_sh_d       = ct_sh_q;
        cache_key_d   = cache_key_q;

        case (state_q)
            IDLE: begin
                if (job_valid && job_ready_q) begin
                    key_d = job_key;
                    pt_d  = job_pt;
                    idx_d = 2'd0;
                    if (KEY_CACHE && cache_valid_q && (job_key == cache_key_q)) begin
                        state_d = WPT;
                    end else begin
                        // Peripheral key is about to change; the cache is stale until readout.
                        state_d       = WKEY;
                        cache_valid_d = 1'b0;
                    end
                end
            end
            WKEY: begin
                if (acc_done) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = WPT;
                end
            end
            WPT: begin
                if (acc_done) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = WCTRL;
                end
            end
            WCTRL: begin
                if (acc_done) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d    = POLL;
                        poll_cnt_d = 16'd0;
                    end
                end
            end
            POLL: begin
                if (acc_done) begin
                    if (m_rdata[STATUS_DONE_BIT]) begin
                        state_d = RDCT;
                        idx_d   = 2'd0;
                    end else if (poll_cnt_q == 16'(POLL_LIMIT - 32'd1)) begin
                        state_d       = RESP;
                        res_valid_d   = 1'b1;
                        res_err_d     = 1'b1;
                        res_ct_d      = '0;
                        cache_valid_d = 1'b0;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
                end
            end
            RDCT: begin
                if (acc_done) begin
                    ct_sh_d = ct_next;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d       = RESP;
                        res_valid_d   = 1'b1;
                        res_err_d     = 1'b0;
                        res_ct_d      = ct_next;
                        cache_key_d   = key_q;
                        cache_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        job_ready_d = (state_d == IDLE);
        bus_d       = bus_req(state_d, idx_d, key_d, pt_d);
    end

    // Control state and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            poll_cnt_q    <= 16'd0;
            cache_valid_q <= 1'b0;
            job_ready_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_err_q     <= 1'b0;
            res_ct_q      <= '0;
            bus_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            poll_cnt_q    <= poll_cnt_d;
            cache_valid_q <= cache_valid_d;
            job_ready_q   <= job_ready_d;
            res_valid_q   <= res_valid_d;
            res_err_q     <= res_err_d;
            res_ct_q      <= res_ct_d;
            bus_q         <= bus_d;
        end
    end

    // Job data, ciphertext assembly and cached key carry no reset.
    always_ff @(posedge clk) begin
        key_q       <= key_d;
        pt_q        <= pt_d;
        ct_sh_q     <= ct_sh_d;
        cache_key_q <= cache_key_d;
    end

    assign job_ready = job_ready_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign res_ct    = res_ct_q;
    assign m_valid   = bus_q.valid;
    assign m_wen     = bus_q.wen;
    assign m_addr    = bus_q.addr;
    assign m_wdata   = bus_q.wdata;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer with a behavioural picoaes slave model.
module tb_aes_job_sequencer;

    localparam logic [127:0] KAT_KEY = 128'hfb0b38bcad60b76c73377dfd9ce5692f;
    localparam logic [127:0] KAT_PT  = 128'hfb8587bdac1c369369173bceb2ed4785;
    localparam logic [127:0] KAT_CT  = 128'h2287d7fc410a4e2059c15b4a2a2b3375;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [127:0] job_key = '0;
    logic [127:0] job_pt = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [127:0] res_ct;
    logic         res_err;
    logic         m_valid;
    logic         m_wen;
    logic [23:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic         m_ready;

    int total = 0;
    int bad = 0;
    int stall_checks = 0;

    always #5 clk = ~clk;

    aes_job_sequencer #(.POLL_LIMIT(8), .KEY_CACHE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key), .job_pt(job_pt),
        .res_valid(res_valid), .res_ready(res_ready), .res_ct(res_ct), .res_err(res_err),
        .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stand-in for the AES core: the known-answer pair, else a reversible mix.
    function automatic logic [127:0] ct_model(input logic [127:0] k, input logic [127:0] p);
        if (k == KAT_KEY && p == KAT_PT) return KAT_CT;
        return k ^ {p[95:0], p[127:96]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [31:0] ct_word(input logic [127:0] c, input logic [1:0] i);
        logic [31:0] w;
        w = c[127:96];
        case (i)
            2'd0: w = c[127:96];
            2'd1: w = c[95:64];
            2'd2: w = c[63:32];
            2'd3: w = c[31:0];
            default: w = c[127:96];
        endcase
        return w;
    endfunction

    // ---------------- picoaes slave model ----------------
    logic [31:0]  key_r [4];
    logic [31:0]  pt_r [4];
    int           ctrl_cnt;
    logic         started;
    int           stat_reads;
    logic [127:0] ct_r;
    logic         hang = 1'b0;
    int           done_after = 1;
    logic         stall_mode = 1'b0;
    logic [23:0]  tr_addr [$];
    logic         tr_wen [$];
    logic [31:0]  tr_wdata [$];

    always @(posedge clk) begin
        if (reset) begin
            ctrl_cnt   <= 0;
            started    <= 1'b0;
            stat_reads <= 0;
        end else if (m_valid && m_ready) begin
            tr_addr.push_back(m_addr);
            tr_wen.push_back(m_wen);
            tr_wdata.push_back(m_wdata);
            if (m_wen) begin
                if (m_addr >= 24'h04 && m_addr <= 24'h10) key_r[m_addr[3:2] - 2'd1] <= m_wdata;
                else if (m_addr >= 24'h14 && m_addr <= 24'h20) pt_r[m_addr[3:2] - 2'd1] <= m_wdata;
                else if (m_addr == 24'h00) begin
                    ctrl_cnt <= ctrl_cnt + 1;
                    if (ctrl_cnt == 0) started <= 1'b0;
                    if (ctrl_cnt == 3) begin
                        ctrl_cnt   <= 0;
                        started    <= 1'b1;
                        stat_reads <= 0;
                        ct_r <= ct_model({key_r[0], key_r[1], key_r[2], key_r[3]},
                                         {pt_r[0], pt_r[1], pt_r[2], pt_r[3]});
                    end
                end
            end else if (m_addr == 24'h44) begin
                stat_reads <= stat_reads + 1;
            end
        end
    end

    always_comb begin
        m_rdata = 32'h0;
        if (m_addr == 24'h44)
            m_rdata = {31'd0, started && !hang && ((stat_reads + 1) >= done_after)};
        else if (m_addr >= 24'h34 && m_addr <= 24'h40)
            m_rdata = ct_word(ct_r, m_addr[3:2] - 2'd1);
    end

    // m_ready driver plus stall-stability and read-data monitor, at negedge.
    initial begin
        int   stall_left;
        logic prev_stall;
        logic prev_rst;
        logic [56:0] prev_bus;
        stall_left = 0;
        prev_stall = 1'b0;
        prev_rst   = 1'b1;
        prev_bus   = '0;
        m_ready    = 1'b1;
        forever begin
            @(negedge clk);
            if (!stall_mode) m_ready = 1'b1;
            else if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = 1'b1;
                stall_left = $urandom_range(0, 3);
            end
            if (prev_stall && !prev_rst && !reset) begin
                chk("stall_hold", 128'({m_valid, m_wen, m_addr, m_wdata}), 128'({1'b1, prev_bus}));
                stall_checks++;
            end
            if (m_valid === 1'b1 && m_wen === 1'b0) chk("rd_wdata_zero", 128'(m_wdata), 128'd0);
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_rst   = reset;
            prev_bus   = {m_wen, m_addr, m_wdata};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int count_acc(input int base, input logic [23:0] lo, input logic [23:0] hi);
        int n;
        n = 0;
        for (int i = base; i < tr_addr.size(); i++)
            if (tr_addr[i] >= lo && tr_addr[i] <= hi) n++;
        return n;
    endfunction

    // Offer a job, wait for its result, check it, optionally stall res_ready.
    task automatic run_job(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] ec, input logic ee, input int ecyc, input int hold);
        int n;
        bit ok;
        job_key = k;
        job_pt = p;
        job_valid = 1'b1;
        n = 0;
        while (job_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (job_ready !== 1'b1) begin
            chk({tag, "_accept_timeout"}, 128'd0, 128'd1);
            job_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        job_key = ~k;
        job_pt = ~p;
        n = 0;
        ok = 0;
        while (n < 1000 && !ok) begin
            @(negedge clk);
            n++;
            if (res_valid === 1'b1) ok = 1;
        end
        if (!ok) begin
            chk({tag, "_result_timeout"}, 128'd0, 128'd1);
            return;
        end
        if (ecyc >= 0) chk({tag, "_latency"}, 128'(n), 128'(ecyc));
        chk({tag, "_ct"}, res_ct, ec);
        chk({tag, "_err"}, 128'(res_err), 128'(ee));
        chk({tag, "_busy_ready"}, 128'(job_ready), 128'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 128'(res_valid), 128'd1);
            chk({tag, "_hold_ct"}, res_ct, ec);
            chk({tag, "_hold_ready"}, 128'(job_ready), 128'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_res_drop"}, 128'(res_valid), 128'd0);
        chk({tag, "_ready_back"}, 128'(job_ready), 128'd1);
    endtask

    initial begin
        logic [23:0]  exp_addr [19];
        logic [31:0]  exp_ctrl [4];
        logic [127:0] kk, kp, k3, p2, p3, p4, p5, p6;
        int base;
        int n;
        exp_addr = '{24'h10, 24'h0C, 24'h08, 24'h04, 24'h20, 24'h1C, 24'h18, 24'h14,
                     24'h00, 24'h00, 24'h00, 24'h00, 24'h44, 24'h44, 24'h44,
                     24'h40, 24'h3C, 24'h38, 24'h34};
        exp_ctrl = '{32'h6, 32'h6, 32'h4, 32'h4};
        kk = KAT_KEY;
        kp = KAT_PT;
        k3 = 128'h00112233445566778899aabbccddeeff;
        p2 = 128'h3243f6a8885a308d313198a2e0370734;
        p3 = 128'hdeadbeefcafef00d0123456789abcdef;
        p4 = 128'h55aa55aa00ff00ff1234567890abcdef;
        p5 = 128'h0badf00d0badf00d0badf00d0badf00d;
        p6 = 128'hfedcba98765432100123456789abcdef;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_job_ready", 128'(job_ready), 128'd0);
        chk("rst_res_valid", 128'(res_valid), 128'd0);
        chk("rst_res_err", 128'(res_err), 128'd0);
        chk("rst_res_ct", res_ct, 128'd0);
        chk("rst_m_valid", 128'(m_valid), 128'd0);
        chk("rst_m_wen", 128'(m_wen), 128'd0);
        chk("rst_m_addr", 128'(m_addr), 128'd0);
        chk("rst_m_wdata", 128'(m_wdata), 128'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_job_ready", 128'(job_ready), 128'd1);

        // Known-answer job, uncached, 3 STATUS reads
        done_after = 3;
        base = tr_addr.size();
        run_job("kat", kk, kp, KAT_CT, 1'b0, 20, 0);
        chk("kat_trace_len", 128'(tr_addr.size() - base), 128'd19);
        for (int i = 0; i < 19; i++) chk("kat_addr", 128'(tr_addr[base + i]), 128'(exp_addr[i]));
        for (int i = 0; i < 4; i++) chk("kat_ctrl_data", 128'(tr_wdata[base + 8 + i]), 128'(exp_ctrl[i]));
        chk("kat_key_w3", 128'(tr_wdata[base]), 128'(kk[31:0]));
        chk("kat_key_w0", 128'(tr_wdata[base + 3]), 128'(kk[127:96]));
        chk("kat_pt_w3", 128'(tr_wdata[base + 4]), 128'(kp[31:0]));
        chk("kat_pt_w0", 128'(tr_wdata[base + 7]), 128'(kp[127:96]));
        chk("kat_wen_ctrl", 128'(tr_wen[base + 11]), 128'd1);
        chk("kat_wen_poll", 128'(tr_wen[base + 12]), 128'd0);

        // Same key: key writes skipped
        done_after = 1;
        base = tr_addr.size();
        run_job("cached", kk, p2, ct_model(kk, p2), 1'b0, 14, 0);
        chk("cached_key_writes", 128'(count_acc(base, 24'h04, 24'h10)), 128'd0);
        chk("cached_pt_writes", 128'(count_acc(base, 24'h14, 24'h20)), 128'd4);

        // Random slave stalls, new key
        stall_mode = 1'b1;
        done_after = 2;
        run_job("stall", k3, p3, ct_model(k3, p3), 1'b0, -1, 0);
        stall_mode = 1'b0;
        chk("stall_seen", 128'(stall_checks > 0), 128'd1);

        // STATUS never done: timeout after 8 reads
        hang = 1'b1;
        base = tr_addr.size();
        run_job("hang", k3, p4, 128'd0, 1'b1, 17, 0);
        hang = 1'b0;
        chk("hang_status_reads", 128'(count_acc(base, 24'h44, 24'h44)), 128'd8);
        chk("hang_ct_reads", 128'(count_acc(base, 24'h34, 24'h40)), 128'd0);
        base = tr_addr.size();
        done_after = 1;
        run_job("after_hang", k3, p4, ct_model(k3, p4), 1'b0, 18, 0);
        chk("after_hang_key_writes", 128'(count_acc(base, 24'h04, 24'h10)), 128'd4);

        // Reset during WPT on a cached job
        job_key = k3;
        job_pt = p5;
        job_valid = 1'b1;
        n = 0;
        while (job_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstjob_ready", 128'(job_ready), 128'd1);
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        @(negedge clk);
        chk("rstjob_wpt_valid", 128'(m_valid), 128'd1);
        chk("rstjob_wpt_addr", 128'(m_addr), 128'h20);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstjob_m_valid_drop", 128'(m_valid), 128'd0);
        chk("rstjob_ready_low", 128'(job_ready), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstjob_ready_back", 128'(job_ready), 128'd1);
        base = tr_addr.size();
        run_job("post_rst", k3, p5, ct_model(k3, p5), 1'b0, 18, 0);
        chk("post_rst_key_writes", 128'(count_acc(base, 24'h04, 24'h10)), 128'd4);

        // Result held with res_ready low for 5 cycles
        done_after = 2;
        run_job("hold", k3, p6, ct_model(k3, p6), 1'b0, 15, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
